// File: rtl/majority_bist_ctrl.sv
// BIST sequencer for a three-input majority gate: sweeps all eight patterns, checks against a golden majority.
// Optional MAJORITY_BIST_LOG_EN adds first-failure logging ports (first_fail_valid, first_fail_pattern).
module majority_bist_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int SWEEPS        = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [2:0] pattern,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_count
`ifdef MAJORITY_BIST_LOG_EN
  ,
  output logic       first_fail_valid,
  output logic [2:0] first_fail_pattern
`endif
);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  localparam logic [3:0] LAST_SETTLE = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] LAST_SWEEP  = 3'(SWEEPS - 1);

  state_t     state_q, state_d;
  logic [2:0] pattern_q, pattern_d;
  logic [3:0] settle_q, settle_d;
  logic [2:0] sweep_q, sweep_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] fail_q, fail_d;
  logic       expected;
  logic       mismatch;

`ifdef MAJORITY_BIST_LOG_EN
  logic       ff_valid_q, ff_valid_d;
  logic [2:0] ff_pattern_q, ff_pattern_d;
`endif

  assign expected = (pattern_q[0] & pattern_q[1]) |
                    (pattern_q[0] & pattern_q[2]) |
                    (pattern_q[1] & pattern_q[2]);
  assign mismatch = (dut_out != expected);

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    settle_d  = settle_q;
    sweep_d   = sweep_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    fail_d    = fail_q;
`ifdef MAJORITY_BIST_LOG_EN
    ff_valid_d   = ff_valid_q;
    ff_pattern_d = ff_pattern_q;
`endif
    case (state_q)
      IDLE: begin
        pattern_d = 3'b000;
        if (start) begin
          state_d  = APPLY;
          fail_d   = 4'd0;
          pass_d   = 1'b0;
          settle_d = 4'd0;
          sweep_d  = 3'd0;
`ifdef MAJORITY_BIST_LOG_EN
          ff_valid_d   = 1'b0;
          ff_pattern_d = 3'b000;
`endif
        end
      end
      APPLY: begin
        settle_d = settle_q + 4'd1;
        if (settle_q == LAST_SETTLE) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (mismatch && (fail_q != 4'd15)) begin
          fail_d = fail_q + 4'd1;
        end
`ifdef MAJORITY_BIST_LOG_EN
        if (mismatch && !ff_valid_q) begin
          ff_valid_d   = 1'b1;
          ff_pattern_d = pattern_q;
        end
`endif
        // pass must reflect the final sample, so it is taken from fail_d rather than fail_q
        if ((pattern_q == 3'b111) && (sweep_q == LAST_SWEEP)) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (fail_d == 4'd0);
        end else begin
          pattern_d = pattern_q + 3'd1;
          if (pattern_q == 3'b111) begin
            sweep_d = sweep_q + 3'd1;
          end
          settle_d = 4'd0;
          state_d  = APPLY;
        end
      end
      DONE: begin
        pattern_d = 3'b000;
        state_d   = IDLE;
      end
      default: begin
        state_d   = IDLE;
        pattern_d = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pattern_q <= 3'b000;
      settle_q  <= 4'd0;
      sweep_q   <= 3'd0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 4'd0;
`ifdef MAJORITY_BIST_LOG_EN
      ff_valid_q   <= 1'b0;
      ff_pattern_q <= 3'b000;
`endif
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      settle_q  <= settle_d;
      sweep_q   <= sweep_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
`ifdef MAJORITY_BIST_LOG_EN
      ff_valid_q   <= ff_valid_d;
      ff_pattern_q <= ff_pattern_d;
`endif
    end
  end

  assign pattern    = pattern_q;
  assign busy       = (state_q == APPLY) || (state_q == SAMPLE);
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_count = fail_q;
`ifdef MAJORITY_BIST_LOG_EN
  assign first_fail_valid   = ff_valid_q;
  assign first_fail_pattern = ff_pattern_q;
`endif

endmodule

// File: tb/tb_majority_bist_ctrl.sv
// Directed self-checking bench for majority_bist_ctrl: three instances cover default,
// multi-sweep saturation and single-cycle settle configurations.
module tb_majority_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start0, start1, start2;
  int   mode0, mode1, mode2;
  int   sel;
  int   cycle;
  int   total = 0;
  int   bad = 0;

  logic [2:0] pat0, pat1, pat2;
  logic       dout0, dout1, dout2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;
  logic       pass0, pass1, pass2;
  logic [3:0] fc0, fc1, fc2;
`ifdef MAJORITY_BIST_LOG_EN
  logic       ffv0, ffv1, ffv2;
  logic [2:0] ffp0, ffp1, ffp2;
`endif

  logic [2:0] pat;
  logic       busy, done, pass;
  logic [3:0] fc;

  // Golden majority used by the gate models (mode 0 correct, 1 stuck-at-0, 2 inverted)
  function automatic logic maj(input logic [2:0] p);
    return (p[0] & p[1]) | (p[0] & p[2]) | (p[1] & p[2]);
  endfunction

  function automatic logic gate(input int mode, input logic [2:0] p);
    if (mode == 1) return 1'b0;
    if (mode == 2) return ~maj(p);
    return maj(p);
  endfunction

  always_comb begin
    dout0 = gate(mode0, pat0);
    dout1 = gate(mode1, pat1);
    dout2 = gate(mode2, pat2);
  end

  always_comb begin
    pat = pat0; busy = busy0; done = done0; pass = pass0; fc = fc0;
    if (sel == 1) begin
      pat = pat1; busy = busy1; done = done1; pass = pass1; fc = fc1;
    end else if (sel == 2) begin
      pat = pat2; busy = busy2; done = done2; pass = pass2; fc = fc2;
    end
  end

  majority_bist_ctrl #(.SETTLE_CYCLES(2), .SWEEPS(1)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .pattern(pat0), .dut_out(dout0),
    .busy(busy0), .done(done0), .pass(pass0), .fail_count(fc0)
`ifdef MAJORITY_BIST_LOG_EN
    , .first_fail_valid(ffv0), .first_fail_pattern(ffp0)
`endif
  );

  majority_bist_ctrl #(.SETTLE_CYCLES(2), .SWEEPS(3)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .pattern(pat1), .dut_out(dout1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_count(fc1)
`ifdef MAJORITY_BIST_LOG_EN
    , .first_fail_valid(ffv1), .first_fail_pattern(ffp1)
`endif
  );

  majority_bist_ctrl #(.SETTLE_CYCLES(1), .SWEEPS(1)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .pattern(pat2), .dut_out(dout2),
    .busy(busy2), .done(done2), .pass(pass2), .fail_count(fc2)
`ifdef MAJORITY_BIST_LOG_EN
    , .first_fail_valid(ffv2), .first_fail_pattern(ffp2)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
    cycle++;
  endtask

  task automatic applyStimulus(input logic s);
    start0 = (sel == 0) ? s : 1'b0;
    start1 = (sel == 1) ? s : 1'b0;
    start2 = (sel == 2) ? s : 1'b0;
  endtask

  // One complete run on the selected instance; accept edge is cycle 0
  task automatic doRun(input int settle, input int sweeps, input int expFail, input logic expPass);
    int doneCyc;
    doneCyc = 8 * sweeps * (settle + 1) + 1;
    cycle = 0;
    applyStimulus(1'b1);
    stepCycle();
    applyStimulus(1'b0);
    checkOutput("accept_fail_clear", 32'(fc), 0);
    checkOutput("accept_pass_clear", 32'(pass), 0);
    for (int c = 1; c < doneCyc; c++) begin
      checkOutput("run_busy", 32'(busy), 1);
      checkOutput("run_done_low", 32'(done), 0);
      checkOutput("run_pattern", 32'(pat), 32'(((c - 1) / (settle + 1)) % 8));
      stepCycle();
    end
    checkOutput("done_pulse", 32'(done), 1);
    checkOutput("done_busy_low", 32'(busy), 0);
    checkOutput("done_pass", 32'(pass), 32'(expPass));
    checkOutput("done_fail_count", 32'(fc), 32'(expFail));
    stepCycle();
    checkOutput("after_done_low", 32'(done), 0);
    checkOutput("after_pattern_zero", 32'(pat), 0);
    checkOutput("after_pass_hold", 32'(pass), 32'(expPass));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int doneCount;
    int doneAt;
    reset = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    mode0 = 0; mode1 = 2; mode2 = 0;
    sel = 0;
    cycle = 0;
    @(negedge clk);
    stepCycle();
    stepCycle();

    // Reset values
    checkOutput("reset_pattern", 32'(pat0), 0);
    checkOutput("reset_busy", 32'(busy0), 0);
    checkOutput("reset_done", 32'(done0), 0);
    checkOutput("reset_pass", 32'(pass0), 0);
    checkOutput("reset_fail_count", 32'(fc0), 0);
`ifdef MAJORITY_BIST_LOG_EN
    checkOutput("reset_ff_valid", 32'(ffv0), 0);
    checkOutput("reset_ff_pattern", 32'(ffp0), 0);
`endif
    reset = 1'b0;
    stepCycle();

    // Correct gate, defaults: done in cycle 25, pass
    sel = 0; mode0 = 0;
    doRun(2, 1, 0, 1'b1);

    // Stuck-at-0: patterns 011,101,110,111 mismatch
    mode0 = 1;
    doRun(2, 1, 4, 1'b0);
`ifdef MAJORITY_BIST_LOG_EN
    checkOutput("stuck_ff_valid", 32'(ffv0), 1);
    checkOutput("stuck_ff_pattern", 32'(ffp0), 3);
`endif

    // Rerun with correct gate: accept clears count, pass returns
    mode0 = 0;
    doRun(2, 1, 0, 1'b1);
`ifdef MAJORITY_BIST_LOG_EN
    checkOutput("rerun_ff_valid", 32'(ffv0), 0);
`endif

    // Inverted gate over three sweeps: 24 mismatches saturate at 15, done in cycle 73
    sel = 1;
    doRun(2, 3, 15, 1'b0);

    // Second start at cycle 5 is ignored; single done in cycle 17
    sel = 2;
    cycle = 0;
    applyStimulus(1'b1);
    stepCycle();
    applyStimulus(1'b0);
    doneCount = 0;
    doneAt = -1;
    for (int c = 1; c <= 30; c++) begin
      if (cycle == 5) applyStimulus(1'b1);
      else applyStimulus(1'b0);
      if (done2) begin
        doneCount++;
        doneAt = cycle;
      end
      stepCycle();
    end
    applyStimulus(1'b0);
    checkOutput("ignored_start_done_count", 32'(doneCount), 1);
    checkOutput("ignored_start_done_cycle", 32'(doneAt), 17);
    checkOutput("ignored_start_pass", 32'(pass2), 1);

    // Reset while pattern is 100
    sel = 0; mode0 = 0;
    cycle = 0;
    applyStimulus(1'b1);
    stepCycle();
    applyStimulus(1'b0);
    while (pat0 != 3'b100 && cycle < 40) stepCycle();
    checkOutput("midrun_reached_100", 32'(pat0), 4);
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    checkOutput("midrun_reset_pattern", 32'(pat0), 0);
    checkOutput("midrun_reset_busy", 32'(busy0), 0);
    checkOutput("midrun_reset_fail_count", 32'(fc0), 0);
    checkOutput("midrun_reset_done", 32'(done0), 0);
    checkOutput("midrun_reset_pass", 32'(pass0), 0);
    doneCount = 0;
    for (int c = 0; c < 30; c++) begin
      if (done0) doneCount++;
      stepCycle();
    end
    checkOutput("midrun_no_done", 32'(doneCount), 0);
    checkOutput("midrun_stays_idle", 32'(busy0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
